// File: rtl/sga_pkg.sv
// Shared constants and types for the Snake Game Arcade display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sga_pkg;

  localparam int ROWS      = 6;
  localparam int COLS      = 6;
  localparam int LED_COUNT = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // One-hot row drive pattern for a 3-bit row index
  function automatic logic [ROWS-1:0] row_onehot(input logic [2:0] r);
    logic [ROWS-1:0] m;
    m = '0;
    for (int i = 0; i < ROWS; i++) begin
      m[i] = (r == 3'(i));
    end
    return m;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Clearable up-counter that flags the last cycle of an N-cycle interval.
// Latency: tc_o is combinational from the registered count.
// Backpressure: none; the owner clears it on every interval start.
module dwell_counter #(
  parameter int W = 4
) (
  input  logic         clock_i,
  input  logic         clr_i,
  input  logic [W:0]   n_i,
  output logic         tc_o
);

  localparam logic [W-1:0] INC = 1;
  localparam logic [W:0]   ONE = 1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign count_d = clr_i ? '0 : (count_q + INC);

  // Count cycles since the last clear
  always_ff @(posedge clock_i) begin
    count_q <= count_d;
  end

  assign tc_o = ({1'b0, count_q} == (n_i - ONE));

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 6x6 LED scanner with a tear-free shadow frame buffer.
// Latency: outputs registered; a new frame appears at the next swap point.
// Backpressure: none; frame_valid pulses between swaps overwrite pending.
module led_matrix_scanner
  import sga_pkg::*;
#(
  parameter int DWELL_CYCLES = 8333,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                 clock_i,
  input  logic                 restart_i,
  input  logic                 enable_i,
  input  logic [LED_COUNT-1:0] frame_i,
  input  logic                 frame_valid_i,
  output logic [ROWS-1:0]      row_sel_o,
  output logic [COLS-1:0]      col_data_o,
  output logic                 frame_done_o,
  output logic [2:0]           db_row_o
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW:0] DWELL_N  = DWELL_CYCLES[CW:0];
  localparam logic [CW:0] BLANK_N  = BLANK_CYCLES[CW:0];
  localparam logic [2:0]  LAST_ROW = 3'(ROWS - 1);

  scan_state_e          state_q;
  logic [2:0]           row_q;
  logic [LED_COUNT-1:0] pending_q;
  logic [LED_COUNT-1:0] active_q;
  logic [ROWS-1:0]      row_sel_q;
  logic [COLS-1:0]      col_data_q;
  logic                 frame_done_q;

  logic [LED_COUNT-1:0] swap_frame_d;
  logic [COLS-1:0]      col_sel_d;
  logic [CW:0]          cnt_n_d;
  logic                 cnt_clr_d;
  logic                 tc;

  // A strobe coinciding with a swap bypasses pending straight into active
  assign swap_frame_d = frame_valid_i ? frame_i : pending_q;

  // Interval length depends on which phase the counter is timing
  assign cnt_n_d = (state_q == SHOW) ? DWELL_N : BLANK_N;

  // Clear on every state change so each state starts counting from zero
  assign cnt_clr_d = restart_i | ~enable_i | (state_q == IDLE) | tc;

  dwell_counter #(
    .W (CW)
  ) u_dwell (
    .clock_i (clock_i),
    .clr_i   (cnt_clr_d),
    .n_i     (cnt_n_d),
    .tc_o    (tc)
  );

  // Select the active-buffer slice for the current row
  always_comb begin
    col_sel_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_q == 3'(r)) begin
        col_sel_d = active_q[r*COLS +: COLS];
      end
    end
  end

  // Scan FSM with buffer management and registered pin drive
  always_ff @(posedge clock_i) begin
    if (restart_i) begin
      state_q      <= IDLE;
      row_q        <= '0;
      pending_q    <= '0;
      active_q     <= '0;
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (frame_valid_i) begin
        pending_q <= frame_i;
      end
      if (!enable_i) begin
        // Disable beats everything, including a coincident wrap
        state_q    <= IDLE;
        row_q      <= '0;
        row_sel_q  <= '0;
        col_data_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q    <= BLANK;
            active_q   <= swap_frame_d;
            row_sel_q  <= '0;
            col_data_q <= '0;
          end
          BLANK: begin
            if (tc) begin
              state_q    <= SHOW;
              row_sel_q  <= row_onehot(row_q);
              col_data_q <= col_sel_d;
            end
          end
          SHOW: begin
            if (tc) begin
              state_q    <= BLANK;
              row_sel_q  <= '0;
              col_data_q <= '0;
              if (row_q == LAST_ROW) begin
                row_q        <= '0;
                active_q     <= swap_frame_d;
                frame_done_q <= 1'b1;
              end else begin
                row_q <= row_q + 3'd1;
              end
            end
          end
          default: begin
            state_q    <= IDLE;
            row_q      <= '0;
            row_sel_q  <= '0;
            col_data_q <= '0;
          end
        endcase
      end
    end
  end

  assign row_sel_o    = row_sel_q;
  assign col_data_o   = col_data_q;
  assign frame_done_o = frame_done_q;
  assign db_row_o     = row_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
`timescale 1ns/1ps
module tb_led_matrix_scanner;
  import sga_pkg::*;

  localparam int DW   = 4;
  localparam int BL   = 1;
  localparam int PER  = DW + BL;
  localparam int FPER = ROWS * PER;

  logic                 clock = 1'b0;
  logic                 restart = 1'b0;
  logic                 enable = 1'b0;
  logic                 frame_valid = 1'b0;
  logic [LED_COUNT-1:0] frame = '0;
  logic [ROWS-1:0]      row_sel;
  logic [COLS-1:0]      col_data;
  logic                 frame_done;
  logic [2:0]           db_row;

  always #5 clock = ~clock;

  led_matrix_scanner #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .clock_i       (clock),
    .restart_i     (restart),
    .enable_i      (enable),
    .frame_i       (frame),
    .frame_valid_i (frame_valid),
    .row_sel_o     (row_sel),
    .col_data_o    (col_data),
    .frame_done_o  (frame_done),
    .db_row_o      (db_row)
  );

  typedef struct packed {
    logic [ROWS-1:0] rs;
    logic [COLS-1:0] cd;
    logic            fd;
    logic [2:0]      row;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: time since enable, displayed frame, pending frame
  bit                   m_run = 1'b0;
  int                   m_k = 0;
  logic [LED_COUNT-1:0] m_pend = '0;
  logic [LED_COUNT-1:0] m_act = '0;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected outputs after one clock edge, derived from the scan timeline
  task automatic model_edge(input logic rst, input logic en, input logic fv,
                            input logic [LED_COUNT-1:0] fr);
    exp_t e;
    int   p;
    int   r;
    if (rst) begin
      m_run  = 1'b0;
      m_k    = 0;
      m_pend = '0;
      m_act  = '0;
    end else begin
      if (!en) begin
        m_run = 1'b0;
        m_k   = 0;
      end else if (!m_run) begin
        m_run = 1'b1;
        m_k   = 1;
        m_act = fv ? fr : m_pend;
      end else begin
        m_k++;
        if ((m_k - 1) % FPER == 0) m_act = fv ? fr : m_pend;
      end
      if (fv) m_pend = fr;
    end
    e = '0;
    if (m_run) begin
      p     = (m_k - 1) % PER;
      r     = ((m_k - 1) / PER) % ROWS;
      e.row = 3'(r);
      if (p >= BL) begin
        e.rs = ROWS'(1) << r;
        e.cd = m_act[r*COLS +: COLS];
      end
      e.fd = (p == 0) && (r == 0) && (m_k > 1);
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic en, input logic fv,
                     input logic [LED_COUNT-1:0] fr);
    @(negedge clock);
    restart     = rst;
    enable      = en;
    frame_valid = fv;
    frame       = fr;
    @(posedge clock);
    model_edge(rst, en, fv, fr);
  endtask

  // Run enabled until the current output cycle sits at a given frame phase
  task automatic wait_phase(input int ph);
    for (int i = 0; i < 2 * FPER; i++) begin
      if (m_run && (m_k % FPER) == ph) return;
      cyc(1'b0, 1'b1, 1'b0, '0);
    end
    tests++;
    fails++;
    $display("FAIL wait_phase: phase %0d not reached, k=%0d", ph, m_k);
  endtask

  function automatic logic [LED_COUNT-1:0] rnd36();
    return {4'($urandom()), 32'($urandom())};
  endfunction

  // Monitor: every output cycle pops one expectation and compares
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("row_sel", int'(row_sel), int'(e.rs));
        check("col_data", int'(col_data), int'(e.cd));
        check("frame_done", int'(frame_done), int'(e.fd));
        check("db_row", int'(db_row), int'(e.row));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stimulus
  initial begin
    logic [LED_COUNT-1:0] fa;
    logic [LED_COUNT-1:0] fb;
    int off;

    // Reset with enable held high, then scan an empty frame
    cyc(1'b1, 1'b1, 1'b0, '0);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, '0);

    // Basic scan: row 0 fully lit, loaded before enable
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 36'h0_0000_003F);
    cyc(1'b0, 1'b0, 1'b0, '0);
    repeat (70) cyc(1'b0, 1'b1, 1'b0, '0);

    // No tearing: new frame mid row 3
    wait_phase(17);
    cyc(1'b0, 1'b1, 1'b1, '1);
    repeat (40) cyc(1'b0, 1'b1, 1'b0, '0);

    // Strobe in the last SHOW cycle of row 5
    wait_phase(0);
    cyc(1'b0, 1'b1, 1'b1, rnd36());
    repeat (35) cyc(1'b0, 1'b1, 1'b0, '0);

    // Enable drop mid row 2, re-enable three cycles later
    wait_phase(13);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0);
    repeat (40) cyc(1'b0, 1'b1, 1'b0, '0);

    // Double strobe within one frame: only B survives
    fa = rnd36();
    fb = rnd36();
    wait_phase(5);
    cyc(1'b0, 1'b1, 1'b1, fa);
    wait_phase(20);
    cyc(1'b0, 1'b1, 1'b1, fb);
    repeat (40) cyc(1'b0, 1'b1, 1'b0, '0);

    // Enable drop exactly at the wrap, with a strobe in the same cycle
    wait_phase(0);
    cyc(1'b0, 1'b0, 1'b1, rnd36());
    cyc(1'b0, 1'b0, 1'b0, '0);
    repeat (35) cyc(1'b0, 1'b1, 1'b0, '0);

    // Strobe coinciding with entry from IDLE
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, rnd36());
    repeat (10) cyc(1'b0, 1'b1, 1'b0, '0);

    // Reset mid-scan
    cyc(1'b1, 1'b1, 1'b0, '0);
    repeat (10) cyc(1'b0, 1'b1, 1'b0, '0);

    // Randomized traffic
    off = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rst;
      logic en;
      logic fv;
      rst = ($urandom_range(0, 499) == 0);
      if (off == 0 && $urandom_range(0, 199) == 0) off = $urandom_range(1, 4);
      en = (off == 0);
      if (off > 0) off--;
      fv = ($urandom_range(0, 24) == 0);
      cyc(rst, en, fv, fv ? rnd36() : '0);
    end

    repeat (2) @(negedge clock);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
